// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse receive path:
//   - morse_state_t : receiver FSM states (IDLE, PRESS, GAP)
//   - CODE_*        : character code values used by the receiver and the LUT
//   - SYM_*         : symbol encoding shifted into the pattern register
//   - CNT_W/CNT_MAX : width and saturation value of the duration counter
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } morse_state_t;

    localparam logic [5:0] CODE_INVALID = 6'd63;
    localparam logic [5:0] CODE_DIGIT0  = 6'd26;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int                CNT_W   = 16;
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

endpackage : morse_pkg

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Purely combinational translation of an accumulated Morse pattern into a
// 6-bit character code (A-Z = 0-25, digits 0-9 = 26-35, anything else = 63).
//
// Pattern convention: the first symbol keyed sits in bit (len-1), the most
// recent one in bit 0; dash = 1, dot = 0. Bits above len-1 are always zero
// because the pattern register starts cleared and only shifts left.
//
// Ports:
//   len     in  3  number of symbols collected (0..5)
//   pattern in  5  collected symbols
//   code    out 6  character code
// -----------------------------------------------------------------------------
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] len,
    input  logic [4:0] pattern,
    output logic [5:0] code
);

    // ITU letter/digit table keyed on {len, pattern}
    always_comb begin
        code = CODE_INVALID;
        case ({len, pattern})
            // one symbol
            8'b001_00000: code = 6'd4;   // E .
            8'b001_00001: code = 6'd19;  // T -
            // two symbols
            8'b010_00000: code = 6'd8;   // I ..
            8'b010_00001: code = 6'd0;   // A .-
            8'b010_00010: code = 6'd13;  // N -.
            8'b010_00011: code = 6'd12;  // M --
            // three symbols
            8'b011_00000: code = 6'd18;  // S ...
            8'b011_00001: code = 6'd20;  // U ..-
            8'b011_00010: code = 6'd17;  // R .-.
            8'b011_00011: code = 6'd22;  // W .--
            8'b011_00100: code = 6'd3;   // D -..
            8'b011_00101: code = 6'd10;  // K -.-
            8'b011_00110: code = 6'd6;   // G --.
            8'b011_00111: code = 6'd14;  // O ---
            // four symbols
            8'b100_00000: code = 6'd7;   // H ....
            8'b100_00001: code = 6'd21;  // V ...-
            8'b100_00010: code = 6'd5;   // F ..-.
            8'b100_00100: code = 6'd11;  // L .-..
            8'b100_00110: code = 6'd15;  // P .--.
            8'b100_00111: code = 6'd9;   // J .---
            8'b100_01000: code = 6'd1;   // B -...
            8'b100_01001: code = 6'd23;  // X -..-
            8'b100_01010: code = 6'd2;   // C -.-.
            8'b100_01011: code = 6'd24;  // Y -.--
            8'b100_01100: code = 6'd25;  // Z --..
            8'b100_01101: code = 6'd16;  // Q --.-
            // five symbols: digits
            8'b101_11111: code = CODE_DIGIT0 + 6'd0;  // 0 -----
            8'b101_01111: code = CODE_DIGIT0 + 6'd1;  // 1 .----
            8'b101_00111: code = CODE_DIGIT0 + 6'd2;  // 2 ..---
            8'b101_00011: code = CODE_DIGIT0 + 6'd3;  // 3 ...--
            8'b101_00001: code = CODE_DIGIT0 + 6'd4;  // 4 ....-
            8'b101_00000: code = CODE_DIGIT0 + 6'd5;  // 5 .....
            8'b101_10000: code = CODE_DIGIT0 + 6'd6;  // 6 -....
            8'b101_11000: code = CODE_DIGIT0 + 6'd7;  // 7 --...
            8'b101_11100: code = CODE_DIGIT0 + 6'd8;  // 8 ---..
            8'b101_11110: code = CODE_DIGIT0 + 6'd9;  // 9 ----.
            default:      code = CODE_INVALID;
        endcase
    end

endmodule : morse_lut

// File: rtl/morse_receiver.sv
// -----------------------------------------------------------------------------
// morse_receiver
// Front end of the Morse path: synchronises and debounces a telegraph key,
// times each press on a slow tick, classifies it as dot or dash, collects up
// to five symbols and emits one character code when the inter-letter gap
// expires.
//
// Parameters:
//   TICK_DIV         clk cycles per timing tick
//   DEB_TICKS        consecutive differing ticks needed to flip key_db
//   DOT_MAX_TICKS    press shorter than this is a dot, otherwise a dash
//   LETTER_GAP_TICKS released time that closes a letter
//
// Ports:
//   clk        in  1  system clock
//   res        in  1  asynchronous active-low reset
//   key_in     in  1  raw key, asynchronous, 1 = pressed
//   data_valid out 1  one-cycle strobe, char_data valid in that cycle
//   char_data  out 6  character code (holds until the next strobe)
// -----------------------------------------------------------------------------
module morse_receiver
    import morse_pkg::*;
#(
    parameter int TICK_DIV         = 100_000,
    parameter int DEB_TICKS        = 5,
    parameter int DOT_MAX_TICKS    = 200,
    parameter int LETTER_GAP_TICKS = 600
) (
    input  logic       clk,
    input  logic       res,
    input  logic       key_in,
    output logic       data_valid,
    output logic [5:0] char_data
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W   = (DEB_TICKS > 0) ? $clog2(DEB_TICKS + 1) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_TICKS - 1);
    localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);
    localparam logic [CNT_W-1:0]   DOT_LIMIT  = CNT_W'(DOT_MAX_TICKS);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(LETTER_GAP_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                key_meta_q;
    logic                key_s_q;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                tick_s;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic                key_db_q, key_db_d;
    logic                key_db_dly_q;
    logic                rise_s, fall_s;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gap_done_s;
    morse_state_t        state_q, state_d;
    logic                cnt_clr_s;
    logic                sym_load_s;
    logic                sym_s;
    logic                sym_clr_s;
    logic                emit_s;
    logic [4:0]          pattern_q, pattern_d;
    logic [2:0]          len_q, len_d;
    logic                ovf_q, ovf_d;
    logic [5:0]          lut_code_s;
    logic                data_valid_q, data_valid_d;
    logic [5:0]          char_data_q, char_data_d;

    // ------------------------------------------------------------------
    // Synchroniser, prescaler and debouncer
    // ------------------------------------------------------------------

    // Two-flop synchroniser for the asynchronous key
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
        end else begin
            key_meta_q <= key_in;
            key_s_q    <= key_meta_q;
        end
    end

    assign tick_s = (presc_q == PRESC_LAST);

    // Prescaler next state: wrap at TICK_DIV-1, tick_s marks the wrap cycle
    always_comb begin
        presc_d = presc_q + PRESC_ONE;
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    // Debouncer next state: flip only after DEB_TICKS consecutive differing ticks
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        key_db_d  = key_db_q;
        if (tick_s) begin
            if (key_s_q != key_db_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    key_db_d  = ~key_db_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end else begin
                deb_cnt_d = '0;
            end
        end else begin
            deb_cnt_d = deb_cnt_q;
        end
    end

    // Prescaler and debouncer registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            presc_q      <= '0;
            deb_cnt_q    <= '0;
            key_db_q     <= 1'b0;
            key_db_dly_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            deb_cnt_q    <= deb_cnt_d;
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_q;
        end
    end

    // Press and release use the same edge detector, so both ends of a press
    // see the same latency and measured durations are unbiased.
    assign rise_s = key_db_q & ~key_db_dly_q;
    assign fall_s = ~key_db_q & key_db_dly_q;

    // The gap closes on the tick that brings the count to LETTER_GAP_TICKS,
    // so the strobe register fires one cycle after that tick.
    assign gap_done_s = tick_s && (cnt_q == GAP_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_d    = state_q;
        cnt_clr_s  = 1'b0;
        sym_load_s = 1'b0;
        sym_s      = SYM_DOT;
        sym_clr_s  = 1'b0;
        emit_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d   = ST_PRESS;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (fall_s) begin
                    sym_load_s = 1'b1;
                    sym_s      = (cnt_q >= DOT_LIMIT) ? SYM_DASH : SYM_DOT;
                    state_d    = ST_GAP;
                    cnt_clr_s  = 1'b1;
                end else begin
                    state_d    = ST_PRESS;
                end
            end
            ST_GAP: begin
                // Emission wins over a coincident rise; that rise is dropped.
                if (gap_done_s) begin
                    emit_s    = 1'b1;
                    sym_clr_s = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_clr_s = 1'b1;
                end else if (rise_s) begin
                    state_d   = ST_PRESS;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d   = ST_GAP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sym_clr_s = 1'b1;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Duration counter and symbol register
    // ------------------------------------------------------------------

    // Duration counter: cleared on transitions and while idle, saturating
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_s || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else if (tick_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Symbol register: shift in new symbols, flag a sixth as overflow
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        if (sym_clr_s) begin
            pattern_d = 5'd0;
            len_d     = 3'd0;
            ovf_d     = 1'b0;
        end else if (sym_load_s) begin
            if (len_q == 3'd5) begin
                ovf_d = 1'b1;
            end else begin
                pattern_d = {pattern_q[3:0], sym_s};
                len_d     = len_q + 3'd1;
            end
        end else begin
            pattern_d = pattern_q;
        end
    end

    // Counter and symbol registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q     <= '0;
            pattern_q <= 5'd0;
            len_q     <= 3'd0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    morse_lut u_lut (
        .len     (len_q),
        .pattern (pattern_q),
        .code    (lut_code_s)
    );

    // Output next state: char_data only changes on an emit
    always_comb begin
        data_valid_d = emit_s;
        char_data_d  = char_data_q;
        if (emit_s) begin
            char_data_d = ovf_q ? CODE_INVALID : lut_code_s;
        end else begin
            char_data_d = char_data_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            data_valid_q <= 1'b0;
            char_data_q  <= 6'd0;
        end else begin
            data_valid_q <= data_valid_d;
            char_data_q  <= char_data_d;
        end
    end

    assign data_valid = data_valid_q;
    assign char_data  = char_data_q;

endmodule : morse_receiver

// File: tb/tb_morse_receiver.sv
// -----------------------------------------------------------------------------
// tb_morse_receiver
// Directed self-checking bench for morse_receiver with shortened timing
// (TICK_DIV=4, DEB_TICKS=2, DOT_MAX_TICKS=10, LETTER_GAP_TICKS=30).
// Key durations are whole multiples of a tick, so the measured press length
// equals the driven length in ticks.
// -----------------------------------------------------------------------------
module tb_morse_receiver;
    import morse_pkg::*;

    localparam int TICK_DIV = 4;

    logic       clk;
    logic       res;
    logic       key_in;
    logic       data_valid;
    logic [5:0] char_data;

    int checks;
    int errors;

    // strobe recorder (single writer: the monitor below)
    int         strobe_cnt;
    logic [5:0] strobe_val [0:63];
    int         db_high_cnt;

    morse_receiver #(
        .TICK_DIV         (4),
        .DEB_TICKS        (2),
        .DOT_MAX_TICKS    (10),
        .LETTER_GAP_TICKS (30)
    ) dut (
        .clk        (clk),
        .res        (res),
        .key_in     (key_in),
        .data_valid (data_valid),
        .char_data  (char_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe and every cycle the debounced key is high
    always @(negedge clk) begin
        if (data_valid) begin
            strobe_val[strobe_cnt % 64] = char_data;
            strobe_cnt = strobe_cnt + 1;
        end
        if (dut.key_db_q) begin
            db_high_cnt = db_high_cnt + 1;
        end
    end

    task automatic hold_key(input logic v, input int ticks);
        @(negedge clk);
        key_in = v;
        repeat (ticks * TICK_DIV - 1) @(negedge clk);
    endtask

    task automatic press(input int ticks);
        hold_key(1'b1, ticks);
    endtask

    task automatic release_key(input int ticks);
        hold_key(1'b0, ticks);
    endtask

    task automatic test_reset();
        res    = 1'b0;
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b expected 0", data_valid);
        end
        checks++;
        if (char_data !== 6'd0) begin
            errors++;
            $display("FAIL reset_char: got %0d expected 0", char_data);
        end
        res = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (strobe_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_strobe: got %0d strobes expected 0", strobe_cnt);
        end
    endtask

    task automatic test_letter_e();
        int base;
        base = strobe_cnt;
        press(5);
        release_key(40);
        checks++;
        if (strobe_cnt - base !== 1) begin
            errors++;
            $display("FAIL e_count: got %0d strobes expected 1", strobe_cnt - base);
        end
        checks++;
        if (strobe_val[base % 64] !== 6'd4) begin
            errors++;
            $display("FAIL e_code: got %0d expected 4", strobe_val[base % 64]);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL e_idle: got state %0d expected %0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_letter_a();
        int base;
        base = strobe_cnt;
        press(5);
        release_key(5);
        press(15);
        release_key(40);
        checks++;
        if (strobe_cnt - base !== 1 || strobe_val[base % 64] !== 6'd0) begin
            errors++;
            $display("FAIL a_code: got %0d strobes code %0d expected 1 strobe code 0",
                     strobe_cnt - base, strobe_val[base % 64]);
        end
    endtask

    task automatic test_dot_dash_boundary();
        int base;
        base = strobe_cnt;
        press(10);
        release_key(40);
        checks++;
        if (strobe_cnt - base !== 1 || strobe_val[base % 64] !== 6'd19) begin
            errors++;
            $display("FAIL boundary_10_dash: got %0d strobes code %0d expected 1 strobe code 19",
                     strobe_cnt - base, strobe_val[base % 64]);
        end
        base = strobe_cnt;
        press(9);
        release_key(40);
        checks++;
        if (strobe_cnt - base !== 1 || strobe_val[base % 64] !== 6'd4) begin
            errors++;
            $display("FAIL boundary_9_dot: got %0d strobes code %0d expected 1 strobe code 4",
                     strobe_cnt - base, strobe_val[base % 64]);
        end
    endtask

    task automatic test_digit_zero();
        int base;
        base = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            press(12);
            release_key(5);
        end
        release_key(40);
        checks++;
        if (strobe_cnt - base !== 1 || strobe_val[base % 64] !== 6'd26) begin
            errors++;
            $display("FAIL digit0: got %0d strobes code %0d expected 1 strobe code 26",
                     strobe_cnt - base, strobe_val[base % 64]);
        end
    endtask

    task automatic test_overflow();
        int base;
        base = strobe_cnt;
        for (int i = 0; i < 6; i++) begin
            press(3);
            release_key(5);
        end
        checks++;
        if (dut.ovf_q !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %0b expected 1", dut.ovf_q);
        end
        release_key(40);
        checks++;
        if (strobe_cnt - base !== 1 || strobe_val[base % 64] !== 6'd63) begin
            errors++;
            $display("FAIL ovf_code: got %0d strobes code %0d expected 1 strobe code 63",
                     strobe_cnt - base, strobe_val[base % 64]);
        end
        checks++;
        if (dut.ovf_q !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared: got %0b expected 0", dut.ovf_q);
        end
    endtask

    task automatic test_unmapped();
        int base;
        base = strobe_cnt;
        press(3);  release_key(5);
        press(3);  release_key(5);
        press(12); release_key(5);
        press(12); release_key(40);
        checks++;
        if (strobe_cnt - base !== 1 || strobe_val[base % 64] !== 6'd63) begin
            errors++;
            $display("FAIL unmapped: got %0d strobes code %0d expected 1 strobe code 63",
                     strobe_cnt - base, strobe_val[base % 64]);
        end
    endtask

    task automatic test_glitch();
        int base;
        int db_base;
        base    = strobe_cnt;
        db_base = db_high_cnt;
        for (int i = 0; i < 6; i++) begin
            press(1);
            release_key(3);
        end
        release_key(40);
        checks++;
        if (db_high_cnt - db_base !== 0) begin
            errors++;
            $display("FAIL glitch_db: key_db high %0d cycles expected 0", db_high_cnt - db_base);
        end
        checks++;
        if (strobe_cnt - base !== 0) begin
            errors++;
            $display("FAIL glitch_strobe: got %0d strobes expected 0", strobe_cnt - base);
        end
    endtask

    task automatic test_reset_mid_letter();
        int base;
        press(3); release_key(5);
        press(3); release_key(3);
        @(negedge clk);
        #2 res = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b0 || char_data !== 6'd0) begin
            errors++;
            $display("FAIL midreset_out: got valid %0b char %0d expected 0 0", data_valid, char_data);
        end
        checks++;
        if (dut.len_q !== 3'd0) begin
            errors++;
            $display("FAIL midreset_len: got %0d expected 0", dut.len_q);
        end
        @(negedge clk);
        res  = 1'b1;
        base = strobe_cnt;
        release_key(100);
        checks++;
        if (strobe_cnt - base !== 0) begin
            errors++;
            $display("FAIL midreset_strobe: got %0d strobes expected 0", strobe_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = strobe_cnt;
        press(12);
        release_key(40);
        checks++;
        if (char_data !== 6'd19) begin
            errors++;
            $display("FAIL b2b_hold_gap: got %0d expected 19", char_data);
        end
        press(5);
        checks++;
        if (char_data !== 6'd19) begin
            errors++;
            $display("FAIL b2b_hold_press: got %0d expected 19", char_data);
        end
        release_key(40);
        checks++;
        if (strobe_cnt - base !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d strobes expected 2", strobe_cnt - base);
        end
        checks++;
        if (strobe_val[base % 64] !== 6'd19 || strobe_val[(base + 1) % 64] !== 6'd4) begin
            errors++;
            $display("FAIL b2b_codes: got %0d,%0d expected 19,4",
                     strobe_val[base % 64], strobe_val[(base + 1) % 64]);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        strobe_cnt  = 0;
        db_high_cnt = 0;
        res         = 1'b0;
        key_in      = 1'b0;
        test_reset();
        test_letter_e();
        test_letter_a();
        test_dot_dash_boundary();
        test_digit_zero();
        test_overflow();
        test_unmapped();
        test_glitch();
        test_reset_mid_letter();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_morse_receiver

// File: doc/morse_receiver.md
# morse_receiver

Front-end stage of the Morse path: turns the raw telegraph-key input into one 6-bit character code per letter, plus a single-cycle `data_valid` strobe for the downstream character decoder.
- Synchronises and debounces the key.
- Times each press against a millisecond-scale tick and classifies it as dot or dash.
- Accumulates up to five symbols.
- Emits the character once the inter-letter gap expires.

## Interface
- `TICK_DIV`, 100_000: clk cycles per timing tick (1 ms at 100 MHz).
- `DEB_TICKS`, 5: ticks the synced key must differ from the debounced level before the level flips.
- `DOT_MAX_TICKS`, 200: press shorter than this is a dot; `>=` is a dash.
- `LETTER_GAP_TICKS`, 600: released time that closes a letter.
- `clk`  in  1  100 MHz system clock.
- `res`  in  1  reset, asynchronous, active-low.
- `key_in`  in  1  raw key, asynchronous to `clk`, 1 = pressed.
- `data_valid`  out  1  one-cycle strobe; `char_data` is valid in that cycle.
- `char_data`  out  6  character code: A–Z = 0–25, digits 0–9 = 26–35, 63 = invalid.

## Operation
- **Synchroniser:** 2-FF synchroniser on `key_in` produces `key_s`.
- **Prescaler:** counts 0..`TICK_DIV`-1; `tick` pulses for one cycle at wrap.
- **Debouncer:**
  - `key_db` flips only after `key_s != key_db` on `DEB_TICKS` consecutive ticks.
  - Any tick with `key_s == key_db` clears the debounce count.
  - `key_db` rise and fall (one-cycle edges) drive the FSM.
- **Duration counter:** 16-bit, cleared on every FSM transition, +1 per tick, saturates at 16'hFFFF.
- **Symbol register:** `pattern[4:0]`, `len[2:0]`, `ovf`.
  - On each symbol: `pattern <= {pattern[3:0], sym}` with dash = 1, dot = 0.
  - `len` increments.
  - If `len` is already 5, set `ovf` and leave `pattern` and `len` unchanged.
- **FSM states:** IDLE, PRESS, GAP.
  - IDLE: `len` = 0, no timing. `key_db` rise → PRESS.
  - PRESS: `key_db` fall → classify with `cnt >= DOT_MAX_TICKS` ? dash : dot, shift the symbol in, → GAP.
  - GAP: `key_db` rise → PRESS (same letter).
  - GAP: `cnt == LETTER_GAP_TICKS` → emit, clear `pattern`/`len`/`ovf`, → IDLE.
- **Emit:**
  - `char_data <= ovf ? 63 : lut(len, pattern)`.
  - Any pattern not in ITU letters/digits maps to 63.
  - `data_valid <= 1` for exactly one cycle.
- **Simultaneous events:** in GAP, a rise in the same cycle the gap count reaches the limit takes the emit path. The rise is then lost, and the key must be re-pressed.
- **Held key:** the counter saturates and the press is classified as a dash on release; there is no timeout emission while pressed.
- **Reset:** mid-letter reset discards the partial pattern, and no emission follows.

## Timing
- **Reset values:**
  - `data_valid` = 0, `char_data` = 0.
  - FSM = IDLE.
  - `key_db` = 0.
  - All counters and `pattern`/`len`/`ovf` = 0.
- **Outputs:** registered; `char_data` holds its last value until the next emit.
- **Key edge latency:** 2 cycles (sync) + `DEB_TICKS` ticks (±1 tick jitter) to `key_db`. This is identical for press and release, so measured durations are unbiased.
- **Emit latency:** `data_valid` asserts 1 cycle after the tick on which the GAP count reaches `LETTER_GAP_TICKS`.
- **Downstream handshake:** none (no back-pressure). The minimum spacing between strobes is `LETTER_GAP_TICKS` ticks.

## Structure
- **Package `morse_pkg`:**
  - FSM state enum.
  - `CODE_INVALID` = 6'd63.
  - `CODE_DIGIT0` = 6'd26.
  - `SYM_DOT`/`SYM_DASH`.
  - Counter width constant (16).
- **Sub-module `morse_lut`:** purely combinational. Inputs `len[2:0]`, `pattern[4:0]`; output `code[5:0]`. Implemented as a case on `{len, pattern}`.
- **Top:** synchroniser, prescaler, debouncer, counter, FSM and output registers stay in `morse_receiver`.

## Test plan
Run with `TICK_DIV`=4, `DEB_TICKS`=2, `DOT_MAX_TICKS`=10, `LETTER_GAP_TICKS`=30.
- **E:** press 5 ticks, release ≥31 ticks → one `data_valid` pulse, `char_data` = 4, then IDLE.
- **A:** dot, 5-tick gap, dash of 15 ticks, then long release → `char_data` = 0. A press of exactly 10 ticks alone → 19 (T), confirming the boundary is a dash.
- **Digit 0:** five dashes → 26. Six dots → 63, with `ovf` set. `..--` → 63 (unmapped).
- **Glitch rejection:** 1-tick pulses on `key_in` → `key_db` never rises, no `data_valid`.
- **Reset mid-letter:** `res` low after two dots → outputs 0 immediately. After release, no `data_valid` appears within 100 ticks.
- **Back-to-back letters:** T then E, each closed by a 30-tick gap → strobes carry 19 then 4. `char_data` holds 19 between the strobes.
